// File: rtl/larger_tb_pkg.sv
// ----------------------------------------------------------------------------
// larger_tb_pkg: shared constants, state encoding and vector-order helper
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package larger_tb_pkg;

  localparam int          NUM_VEC      = 8;
  localparam logic [15:0] POLY_DEFAULT = 16'h1021;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRIVE  = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic logic [2:0] gray3(input logic [2:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/larger_stim_seq_misr.sv
// ----------------------------------------------------------------------------
// misr16: 16-bit multiple-input signature register folding in two bits per step
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module misr16
  import larger_tb_pkg::*;
#(
  parameter logic [15:0] POLY    = POLY_DEFAULT,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [15:0] sig
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {14'b0, din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= RST_VAL;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/larger_stim_seq.sv
// ----------------------------------------------------------------------------
// larger_stim_seq: drives all 8 A/B/C vectors, settles, and signs P/Q into a MISR
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module larger_stim_seq
  import larger_tb_pkg::*;
#(
  parameter int          SETTLE = 1,
  parameter logic [15:0] SEED   = 16'h0000,
  parameter logic [15:0] POLY   = POLY_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  output logic        A,
  output logic        B,
  output logic        C,
  input  logic        P,
  input  logic        Q,
  output logic        sample,
  output logic        busy,
  output logic        done,
  output logic [2:0]  vec_idx,
  output logic [15:0] signature
);

  localparam logic [7:0] C_LAST_CNT = 8'(SETTLE - 1);
  localparam logic [2:0] C_LAST_IDX = 3'(NUM_VEC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] abc_q, abc_d;
  logic       mode_q, mode_d;
  logic       sample_q, sample_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       misr_load;
  logic       misr_en;
  logic [2:0] w_next_idx;

  assign w_next_idx = idx_q + 3'd1;

  // Outputs are registered, so each *_d reflects what the next state presents.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    abc_d     = abc_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    sample_d  = 1'b0;
    done_d    = 1'b0;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_DRIVE;
          cnt_d     = 8'd0;
          idx_d     = 3'd0;
          abc_d     = gray3(3'd0);
          mode_d    = mode;
          busy_d    = 1'b1;
          misr_load = 1'b1;
        end
      end
      ST_DRIVE, ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          abc_d   = 3'd0;
        end else if (state_q == ST_DRIVE) begin
          if (cnt_q == C_LAST_CNT) begin
            state_d  = ST_SAMPLE;
            sample_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          misr_en = 1'b1;
          if (idx_q == C_LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = 8'd0;
            idx_d   = w_next_idx;
            abc_d   = mode_q ? gray3(w_next_idx) : w_next_idx;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      abc_q    <= 3'd0;
      mode_q   <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      abc_q    <= abc_d;
      mode_q   <= mode_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  misr16 #(
    .POLY    (POLY),
    .RST_VAL (SEED)
  ) u_misr (
    .clk  (CLK),
    .rst  (RST),
    .load (misr_load),
    .seed (SEED),
    .en   (misr_en),
    .din  ({P, Q}),
    .sig  (signature)
  );

  assign A       = abc_q[2];
  assign B       = abc_q[1];
  assign C       = abc_q[0];
  assign sample  = sample_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign vec_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_larger_stim_seq.sv
// ----------------------------------------------------------------------------
// tb_larger_stim_seq: two sequencer instances (SETTLE=1 and 3) against a run-time model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_larger_stim_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic       abort;
  logic [1:0] pq_src;   // 0 = real netlist, 1 = forced 11, 2 = random bits
  logic       rnd_p;
  logic       rnd_q;

  logic        a_o [2];
  logic        b_o [2];
  logic        c_o [2];
  logic        p_i [2];
  logic        q_i [2];
  logic        smp [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [2:0]  idx [2];
  logic [15:0] sig [2];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] seed_of(input int i);
    return (i == 0) ? 16'h0000 : 16'hACE1;
  endfunction

  function automatic logic [1:0] pq_of(input logic [2:0] abc);
    case (pq_src)
      2'd0:    return {abc[2] & abc[1] & abc[0], ~abc[1] & abc[0]};
      2'd1:    return 2'b11;
      default: return {rnd_p, rnd_q};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [1:0] w_pq;
    assign w_pq   = pq_of({a_o[g], b_o[g], c_o[g]});
    assign p_i[g] = w_pq[1];
    assign q_i[g] = w_pq[0];
    larger_stim_seq #(
      .SETTLE (settle_of(g)),
      .SEED   (seed_of(g))
    ) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .start     (start),
      .mode      (mode),
      .abort     (abort),
      .A         (a_o[g]),
      .B         (b_o[g]),
      .C         (c_o[g]),
      .P         (p_i[g]),
      .Q         (q_i[g]),
      .sample    (smp[g]),
      .busy      (bsy[g]),
      .done      (dn[g]),
      .vec_idx   (idx[g]),
      .signature (sig[g])
    );
  end

  // Model: t counts edges since the accepting edge; vector = t/(S+1), sample phase = S.
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        sample;
    logic [2:0]  abc;
    logic [2:0]  idx;
    logic [15:0] sig;
    logic [15:0] t;
    logic        mode;
  } mst_t;

  mst_t m [2];

  function automatic logic [2:0] vec_of(input logic md, input int v);
    logic [2:0] gray_tab [8];
    gray_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    return md ? gray_tab[v] : 3'(v);
  endfunction

  function automatic mst_t rst_state(input int i);
    mst_t s;
    s     = '0;
    s.sig = seed_of(i);
    return s;
  endfunction

  function automatic mst_t step(input mst_t s, input int i, input logic st,
                                input logic md, input logic ab);
    mst_t n;
    int   per;
    int   v;
    per      = settle_of(i) + 1;
    n        = s;
    n.done   = 1'b0;
    n.sample = 1'b0;
    if (!s.busy) begin
      if (st && !s.done) begin
        n.busy = 1'b1;
        n.sig  = seed_of(i);
        n.t    = '0;
        n.mode = md;
        n.idx  = 3'd0;
        n.abc  = vec_of(md, 0);
      end
    end else if (ab) begin
      n.busy = 1'b0;
      n.abc  = 3'd0;
    end else begin
      if (s.sample)
        n.sig = {s.sig[14:0], 1'b0} ^ (s.sig[15] ? 16'h1021 : 16'h0000) ^ {14'b0, pq_of(s.abc)};
      n.t = s.t + 16'd1;
      if (int'(n.t) == 8 * per) begin
        n.busy = 1'b0;
        n.done = 1'b1;
      end else begin
        v        = int'(n.t) / per;
        n.idx    = 3'(v);
        n.abc    = vec_of(s.mode, v);
        n.sample = ((int'(n.t) % per) == per - 1);
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) m[i] <= rst_state(i);
    end else begin
      for (int i = 0; i < 2; i++) m[i] <= step(m[i], i, start, mode, abort);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("outs_inst%0d {abc,smp,busy,done,sig}", i),
          {10'd0, a_o[i], b_o[i], c_o[i], smp[i], bsy[i], dn[i], sig[i]},
          {10'd0, m[i].abc, m[i].sample, m[i].busy, m[i].done, m[i].sig});
      if (m[i].busy) chk($sformatf("vec_idx_inst%0d", i), {29'd0, idx[i]}, {29'd0, m[i].idx});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges are counted from the edge just before start is raised.
  task automatic do_run(input logic md, input bit poke,
                        output int d0, output int d1, output int s0, output int s1,
                        output logic [23:0] ord0, output bit gap0_ok, output bit gap1_ok);
    int e     = 0;
    int last0 = -1;
    int last1 = -1;
    d0 = -1; d1 = -1; s0 = 0; s1 = 0; ord0 = '0; gap0_ok = 1'b1; gap1_ok = 1'b1;
    mode  = md;
    start = 1'b1;
    while ((d0 < 0 || d1 < 0) && e < 100) begin
      tick();
      e++;
      start = poke && (e >= 3) && (e <= 14) && (e % 3 == 0);
      if (e == 5) mode = ~md;
      if (smp[0]) begin
        s0++;
        ord0 = {ord0[20:0], a_o[0], b_o[0], c_o[0]};
        if (last0 >= 0 && e - last0 != 2) gap0_ok = 1'b0;
        last0 = e;
      end
      if (smp[1]) begin
        s1++;
        if (last1 >= 0 && e - last1 != 4) gap1_ok = 1'b0;
        last1 = e;
      end
      if (dn[0] && d0 < 0) d0 = e;
      if (dn[1] && d1 < 0) d1 = e;
    end
    start = 1'b0;
  endtask

  int          d0, d1, s0, s1, dn_cnt;
  logic [23:0] ord0;
  bit          g0, g1, found;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    pq_src = 2'd0; rnd_p = 1'b0; rnd_q = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_sig0", {16'd0, sig[0]}, 32'h0000);
    chk("reset_sig1", {16'd0, sig[1]}, 32'hACE1);
    chk("reset_busy_done", {30'd0, bsy[0], dn[0]}, 32'd0);

    // Reset mid-DRIVE.
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #2;
    chk("rst_mid_busy", {30'd0, bsy[0], bsy[1]}, 32'd0);
    chk("rst_mid_abc1", {29'd0, a_o[1], b_o[1], c_o[1]}, 32'd0);
    chk("rst_mid_sig1", {16'd0, sig[1]}, 32'hACE1);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_nodone", {30'd0, dn[0], dn[1]}, 32'd0);

    // Binary golden run with stray starts and a mode flip mid-run.
    do_run(1'b0, 1'b1, d0, d1, s0, s1, ord0, g0, g1);
    chk("bin_done_edge_s1", d0, 17);
    chk("bin_done_edge_s3", d1, 33);
    chk("bin_samples_s1", s0, 8);
    chk("bin_samples_s3", s1, 8);
    chk("bin_gaps", {30'd0, g0, g1}, 32'd3);
    chk("bin_order", {8'd0, ord0}, {8'd0, 24'o01234567});
    chk("bin_sig", {16'd0, sig[0]}, 32'h0046);
    chk("bin_model_sig", {16'd0, m[0].sig}, 32'h0046);
    repeat (5) tick();
    chk("bin_no_rerun", {30'd0, bsy[0], bsy[1]}, 32'd0);

    do_run(1'b1, 1'b0, d0, d1, s0, s1, ord0, g0, g1);
    chk("gray_order", {8'd0, ord0}, {8'd0, 24'o01326754});
    chk("gray_sig", {16'd0, sig[0]}, 32'h004A);
    chk("gray_model_sig", {16'd0, m[0].sig}, 32'h004A);
    tick();

    pq_src = 2'd1;
    do_run(1'b0, 1'b0, d0, d1, s0, s1, ord0, g0, g1);
    chk("pq11_sig", {16'd0, sig[0]}, 32'h0101);
    chk("pq11_samples", s0, 8);
    pq_src = 2'd0;
    tick();

    // Abort while instance 0 samples vector 4.
    mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (smp[0] && idx[0] == 3'd4) found = 1'b1;
      else tick();
    end
    chk("abort_reached", {31'd0, found}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", {29'd0, bsy[0], dn[0], smp[0]}, 32'd0);
    chk("abort_sig", {16'd0, sig[0]}, 32'h0004);
    chk("abort_abc", {29'd0, a_o[0], b_o[0], c_o[0]}, 32'd0);
    dn_cnt = 0;
    repeat (40) begin
      tick();
      if (dn[0]) dn_cnt++;
    end
    chk("abort_no_done", dn_cnt, 0);

    for (int k = 0; k < 600; k++) begin
      start  = ($urandom_range(0, 5) == 0);
      mode   = 1'($urandom_range(0, 1));
      abort  = ($urandom_range(0, 39) == 0);
      pq_src = 2'($urandom_range(0, 2));
      rnd_p  = 1'($urandom_range(0, 1));
      rnd_q  = 1'($urandom_range(0, 1));
      rst    = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
